// File: rtl/acc_pkg.sv
// Shared types and helpers for the sequential matrix-multiply accelerator.
// Latency and backpressure are defined by the users of this package.
package acc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Result width: a sum of mat_size full-precision products never overflows it.
    function automatic int acc_width(input int dat_w, input int mat_size);
        return 2 * dat_w + $clog2(mat_size);
    endfunction

    // Row-major flat index of element (r,c) in an n x n matrix.
    function automatic int idx(input int r, input int c, input int n);
        return r * n + c;
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Combinational multiply-accumulate: acc_out = acc_in + ext(a*b), signed or unsigned.
// Zero latency; no handshake.
module mac_unit #(
    parameter int DAT_W = 8,
    parameter int ACC_W = 18
) (
    input  logic [DAT_W-1:0] a,
    input  logic [DAT_W-1:0] b,
    input  logic [ACC_W-1:0] acc_in,
    input  logic             signed_mode,
    output logic [ACC_W-1:0] acc_out
);

    logic signed [2*DAT_W-1:0] prod_s;
    logic        [2*DAT_W-1:0] prod_u;
    logic signed [ACC_W-1:0]   ext_s;
    logic        [ACC_W-1:0]   ext_u;

    assign prod_s = $signed(a) * $signed(b);
    assign prod_u = a * b;

    // Extension is done on each full-precision product before the add, so the
    // accumulator arithmetic itself is plain modular addition.
    assign ext_s = ACC_W'(prod_s);
    assign ext_u = ACC_W'(prod_u);

    always_comb begin
        acc_out = acc_in;
        if (signed_mode) begin
            acc_out = acc_in + $unsigned(ext_s);
        end else begin
            acc_out = acc_in + ext_u;
        end
    end

endmodule

// File: rtl/matmul_seq_acc.sv
// C = A x B with one time-shared MAC; done pulses MAT_SIZE^3 cycles after start is taken.
// No backpressure: start is only honoured in IDLE, otherwise dropped (no queueing).
module matmul_seq_acc
    import acc_pkg::*;
#(
    parameter int DAT_W    = 8,
    parameter int MAT_SIZE = 4,
    localparam int ACC_W   = acc_width(DAT_W, MAT_SIZE),
    localparam int N_EL    = MAT_SIZE * MAT_SIZE
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        signed_mode,
    input  logic [N_EL-1:0][DAT_W-1:0]  mat_A,
    input  logic [N_EL-1:0][DAT_W-1:0]  mat_B,
    output logic                        busy,
    output logic                        done,
    output logic [N_EL-1:0][ACC_W-1:0]  mat_C
);

    localparam int IDX_W = (MAT_SIZE > 1) ? $clog2(MAT_SIZE) : 1;
    localparam int EL_W  = (N_EL > 1) ? $clog2(N_EL) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(MAT_SIZE - 1);

    state_t state, state_nxt;

    logic [N_EL-1:0][DAT_W-1:0] a_snap;
    logic [N_EL-1:0][DAT_W-1:0] b_snap;
    logic                       sm_snap;
    logic [IDX_W-1:0]           i, j, k;
    logic [ACC_W-1:0]           acc;
    logic [ACC_W-1:0]           mac_sum;
    logic [EL_W-1:0]            a_sel, b_sel, c_sel;
    logic                       i_last, j_last, k_last, elem_last;

    assign i_last    = (i == LAST);
    assign j_last    = (j == LAST);
    assign k_last    = (k == LAST);
    assign elem_last = i_last && j_last && k_last;

    assign a_sel = EL_W'(idx(int'(i), int'(k), MAT_SIZE));
    assign b_sel = EL_W'(idx(int'(k), int'(j), MAT_SIZE));
    assign c_sel = EL_W'(idx(int'(i), int'(j), MAT_SIZE));

    mac_unit #(
        .DAT_W (DAT_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .a           (a_snap[a_sel]),
        .b           (b_snap[b_sel]),
        .acc_in      (acc),
        .signed_mode (sm_snap),
        .acc_out     (mac_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (elem_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_snap  <= '0;
            b_snap  <= '0;
            sm_snap <= 1'b0;
            i       <= '0;
            j       <= '0;
            k       <= '0;
            acc     <= '0;
            mat_C   <= '0;
        end else if (state == IDLE && start) begin
            a_snap  <= mat_A;
            b_snap  <= mat_B;
            sm_snap <= signed_mode;
            i       <= '0;
            j       <= '0;
            k       <= '0;
            acc     <= '0;
        end else if (state == CALC) begin
            if (!k_last) begin
                acc <= mac_sum;
                k   <= k + IDX_W'(1);
            end else begin
                // Last term of a dot product goes straight into C; acc restarts.
                mat_C[c_sel] <= mac_sum;
                acc          <= '0;
                k            <= '0;
                if (j_last) begin
                    j <= '0;
                    i <= i_last ? '0 : i + IDX_W'(1);
                end else begin
                    j <= j + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/matmul_seq_acc.md
Name: matmul_seq_acc

Overview:
- Parametrised, handshaked sequential matrix-multiply accelerator; next generation of the combinational matrix multiplier behind the accelerator top level.
- Computes C = A x B for MAT_SIZE x MAT_SIZE matrices with a single time-shared MAC, in signed or unsigned mode.
- Sits behind the accelerator top level. start/busy/done are driven by the core-side register interface.
- Operands are snapshotted at start, so the core may overwrite its input registers during computation.

Parameters:
- DAT_W, 8, width of each A/B element.
- MAT_SIZE, 4, matrix dimension N (N >= 1); matrices are N x N.
- ACC_W (localparam), 2*DAT_W + $clog2(MAT_SIZE), width of each C element; never overflows.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only in IDLE.
- signed_mode  in  1  1 = two's-complement operands/result, 0 = unsigned; sampled with start.
- mat_A  in  [N*N-1:0][DAT_W-1:0]  element (r,c) at index r*N+c.
- mat_B  in  [N*N-1:0][DAT_W-1:0]  same layout.
- busy  out  1  high while computing.
- done  out  1  one-cycle pulse when mat_C is complete.
- mat_C  out  [N*N-1:0][ACC_W-1:0]  result, same layout.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, all mat_C elements=0; A/B snapshot regs, indices i/j/k and accumulator=0.
- States: IDLE, CALC, DONE.
- IDLE: start=1 at edge T0 → capture mat_A, mat_B, signed_mode into snapshot regs; i=j=k=0; acc=0; busy=1; next state CALC.
- CALC: each edge computes p = A[i][k]*B[k][j].
  - Product and acc are sign-extended if signed_mode else zero-extended to ACC_W.
  - If k<N-1: acc += p, k++.
  - If k==N-1: C[i][j] <= acc+p; acc=0; k=0; j++ (wrap to 0 with i++).
  - After the element (N-1,N-1) is written (edge T0+N^3) → DONE, busy=0, done=1.
- DONE: lasts exactly one cycle; done=0 at next edge; → IDLE.
- Latency: done high in the cycle after edge T0+N^3 (N=4: 64 CALC cycles). Next start is accepted at edge T0+N^3+2 at the earliest.
- Control input rules:
  - start while busy or in DONE is ignored; there is no queueing.
  - mat_A/mat_B/signed_mode changes after T0 have no effect on the running job.
- mat_C rules:
  - Elements update individually during CALC; they are valid only from done onward.
  - Contents hold until overwritten by the next job or cleared by reset.
- Reset mid-CALC: immediate abort; all outputs return to reset values; no done pulse.
- N=1: one CALC cycle; C[0][0]=A[0][0]*B[0][0]; done high after edge T0+1.
- Arithmetic: the full-precision product is 2*DAT_W. Sums of N products fit ACC_W in both modes, so there is no saturation or wrap.

Decomposition:
- Package acc_pkg:
  - state enum (IDLE, CALC, DONE).
  - function acc_width(dat_w, mat_size).
  - index helper idx(r,c,n)=r*n+c.
- Sub-module mac_unit (DAT_W, ACC_W):
  - Combinational signed/unsigned multiply plus extension plus add.
  - Inputs a, b, acc_in, signed_mode; output acc_out.
- The FSM, counters, snapshot regs and C register file stay in matmul_seq_acc.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with no clock edge → busy=0, done=0, all mat_C=0 immediately.
- Identity, unsigned, N=4:
  - Stimulus: A=I, B[r][c]=r*4+c, start at T0.
  - Response: done single pulse after edge T0+64; mat_C==B; busy high for exactly 64 cycles.
- Unsigned max, N=4:
  - Stimulus: all A,B=0xFF, signed_mode=0.
  - Response: every C element = 260100 (0x3F804), within 18 bits.
- Signed extremes, N=4, signed_mode=1:
  - Case 1: all A,B=0x80 → every C=65536.
  - Case 2: A all 0xFF (-1), B all 0x01 → every C = -4 (0x3FFFC).
- Protocol: mat_A, mat_B, signed_mode changed and start pulsed again at T0+10 → ignored; result matches original operands; done exactly once.
- Abort: rst_n low at T0+30 then released, then a fresh identity job → no done for the aborted job; second job correct with fresh 64-cycle latency.
